// File: rtl/mul_seq_ctrl.sv
// Purpose: shift-add multiplier sequencer; borrows one external 32-bit adder to form the low WIDTH bits of op_a*op_b.
// Latency: start edge E0 -> done/product visible after edge E0+WIDTH; next start accepted at E0+WIDTH+2.
// Backpressure: start is ignored while busy (RUN/DONE); there is no queuing, so the caller must wait for busy=0.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath: one accumulate step per RUN cycle, fixed WIDTH iterations, no early exit.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          m_d     = op_a;
          q_d     = op_b;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d   = add_s;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          product_d = add_s;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over start and aborts any running multiply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Adder operands come only from registered state so the adder path starts at a flop.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == ST_RUN) begin
      add_a = p_q;
      add_b = q_q[0] ? m_q : '0;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product, add_a, add_b, add_s;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational adder.
  assign add_s = add_a + add_b;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .product(product),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_s  (add_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string name);
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 || add_a !== 32'h0 || add_b !== 32'h0) begin
      miss++;
      $display("FAIL %s: busy=%b done=%b product=%h add_a=%h add_b=%h, required all zero",
               name, busy, done, product, add_a, add_b);
    end
  endtask

  // Runs one multiply from IDLE; checks adder operands per RUN cycle, done timing, busy length, result.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_p,
                         input string name);
    int done_cnt, busy_cnt, done_k;
    logic [31:0] mm, mq, mp, exp_b, prod_at_done;
    op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    mm = a; mq = b; mp = 32'h0;
    done_cnt = 0; busy_cnt = 0; done_k = -1; prod_at_done = 32'hx;
    for (int k = 0; k < 36; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_k = k; prod_at_done = product; end
      if (k < 32) begin
        exp_b = mq[0] ? mm : 32'h0;
        vec++;
        if (add_a !== mp || add_b !== exp_b) begin
          miss++;
          $display("FAIL %s adder k=%0d: add_a=%h add_b=%h, required %h %h", name, k, add_a, add_b, mp, exp_b);
        end
        mp = mp + exp_b; mm = mm << 1; mq = mq >> 1;
      end else begin
        vec++;
        if (add_a !== 32'h0 || add_b !== 32'h0) begin
          miss++;
          $display("FAIL %s adder idle k=%0d: add_a=%h add_b=%h, required 0 0", name, k, add_a, add_b);
        end
      end
      step();
    end
    vec++;
    if (done_k !== 32 || done_cnt !== 1) begin
      miss++;
      $display("FAIL %s done: at k=%0d count=%0d, required k=32 count=1", name, done_k, done_cnt);
    end
    vec++;
    if (busy_cnt !== 33) begin
      miss++;
      $display("FAIL %s busy_len: %0d, required 33", name, busy_cnt);
    end
    vec++;
    if (prod_at_done !== exp_p || product !== exp_p) begin
      miss++;
      $display("FAIL %s product: at_done=%h held=%h, required %h", name, prod_at_done, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = 32'h0; op_b = 32'h0;
    step(); step();
    check_idle_zero("reset_state");
    rst_n = 1'b1;
    step();
    check_idle_zero("after_reset_idle");
  endtask

  task automatic test_basic();
    run_mul(32'd3, 32'd5, 32'd15, "basic_3x5");
  endtask

  task automatic test_wrap();
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ffff");
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap_2p32");
    run_mul(32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, "wrap_mixed");
  endtask

  task automatic test_zero_identity();
    run_mul(32'h0, 32'hDEAD_BEEF, 32'h0, "zero_x");
    run_mul(32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEEF, "identity");
  endtask

  // start held high throughout: second op only at E0+34, operands swapped to 1x1 during RUN.
  task automatic test_back_to_back();
    int done_cnt, first_k, second_k;
    logic [31:0] p1, p2;
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    step();
    op_a = 32'd1; op_b = 32'd1;
    done_cnt = 0; first_k = -1; second_k = -1; p1 = 32'hx; p2 = 32'hx;
    for (int k = 0; k < 70; k++) begin
      if (k == 33) begin
        vec++;
        if (busy !== 1'b0) begin
          miss++;
          $display("FAIL b2b idle_gap: busy=%b at k=33, required 0", busy);
        end
      end
      if (k == 34) begin
        vec++;
        if (busy !== 1'b1) begin
          miss++;
          $display("FAIL b2b second_accept: busy=%b at k=34, required 1", busy);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (first_k < 0) begin first_k = k; p1 = product; end
        else begin second_k = k; p2 = product; end
      end
      step();
    end
    start = 1'b0;
    vec++;
    if (first_k !== 32 || p1 !== 32'd42) begin
      miss++;
      $display("FAIL b2b first: k=%0d product=%0d, required k=32 product=42", first_k, p1);
    end
    vec++;
    if (second_k !== 66 || p2 !== 32'd1 || done_cnt !== 2) begin
      miss++;
      $display("FAIL b2b second: k=%0d product=%0d dones=%0d, required k=66 product=1 dones=2",
               second_k, p2, done_cnt);
    end
    repeat (40) step();
  endtask

  task automatic test_reset_mid_op();
    int bad;
    op_a = 32'd100; op_b = 32'd100; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    check_idle_zero("mid_reset");
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    vec++;
    if (bad !== 0) begin
      miss++;
      $display("FAIL mid_reset_no_done: %0d cycles with busy/done set, required 0", bad);
    end
    run_mul(32'd9, 32'd9, 32'd81, "after_abort_9x9");
  endtask

  task automatic test_reset_start_collision();
    rst_n = 1'b0; start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    step();
    vec++;
    if (busy !== 1'b0) begin
      miss++;
      $display("FAIL collision_edge: busy=%b, required 0", busy);
    end
    start = 1'b0; rst_n = 1'b1;
    step();
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miss++;
      $display("FAIL collision_after: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_identity();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_start_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential shift-add multiplier controller that time-multiplexes one external 32-bit combinational adder (`full_adder_32`) to compute the low 32 bits of an unsigned product over a fixed 32 iterations. It sits beside the ALU in the CPU datapath and owns the adder's operand inputs while a multiply is running. Operands are captured on a start pulse, and a one-cycle done strobe flags a valid product.

## Interface
- `WIDTH`, 32: operand, product and adder width; iteration count equals `WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op_a`  in  WIDTH  multiplicand; captured on accepted start.
- `op_b`  in  WIDTH  multiplier; captured on accepted start.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle strobe; `product` valid.
- `product`  out  WIDTH  low WIDTH bits of `op_a*op_b`; held until next accepted start.
- `add_a`  out  WIDTH  adder operand A.
- `add_b`  out  WIDTH  adder operand B.
- `add_s`  in  WIDTH  adder sum (combinational from `add_a`/`add_b`; no carry-in, no carry-out).

## Operation
- Internal registers: `M` (multiplicand), `Q` (multiplier), `P` (accumulator), `cnt` (clog2(WIDTH)+1 bits).
- State machine:
  - IDLE: `busy`=0. If `start`=1 at an edge, then `M`<=`op_a`, `Q`<=`op_b`, `P`<=0, `cnt`<=0, and the state moves to RUN.
  - RUN: drive `add_a`=`P`, `add_b`=`Q[0]` ? `M` : 0. Each edge: `P`<=`add_s`, `M`<=`M`<<1 (zero fill), `Q`<=`Q`>>1 (zero fill), `cnt`<=`cnt`+1. When `cnt`=WIDTH-1 at the edge, `product`<=`add_s` and the state moves to DONE.
  - DONE: `done`=1 for exactly one cycle; the state then moves to IDLE unconditionally.
- Outside RUN, `add_a`=`add_b`=0.
- Arithmetic is modulo 2^WIDTH; overflow is discarded silently, with no flag.
- Fixed iteration count; there is no early exit when `Q` reaches 0.
- `start` in RUN or DONE is ignored; no queuing.
- `op_a`/`op_b` may change freely after the accepting edge.
- Reset (`rst_n`=0 at an edge, any state, including mid-RUN) has the following effect:
  - state <= IDLE;
  - `M`, `Q`, `P`, `cnt`, `product` <= 0;
  - `done`=0, `busy`=0, `add_a`=`add_b`=0.
  - An aborted operation produces no `done`.
- Reset has priority over `start` in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, `add_a`=0, `add_b`=0.
- Start accepted at edge E0.
- RUN occupies the cycles after E0 through edge E0+WIDTH (32 add edges).
- `done`=1 and the new `product` are visible in the cycle after edge E0+32.
- IDLE is entered after edge E0+33.
- Earliest next start is accepted at E0+34, giving a throughput of one multiply per 34 cycles.
- `busy` rises in the cycle after E0 and falls in the cycle after E0+33.
- `done` and `busy`=1 coincide in the DONE cycle.
- `add_a`/`add_b` are combinational from registered state (no input-to-output path); the adder's combinational delay must close within one `clk` period.
- `product` changes only at the final RUN edge and on reset.

## Test plan
- Basic: reset, then `start` with `op_a`=3, `op_b`=5 -> `done` is a single-cycle pulse 33 cycles after the start edge, `product`=15, and `busy` is high for exactly 33 cycles.
- Wrap: `op_a`=`op_b`=0xFFFFFFFF -> `product`=0x00000001; `op_a`=`op_b`=0x00010000 -> `product`=0x00000000; `op_a`=0x12345678, `op_b`=0x9ABCDEF0 -> `product`=0x242D2080.
- Ignored start: `start` held high continuously with `op_a`=7, `op_b`=6, and operands changed to 1/1 during RUN -> first `product`=42 with one `done`; the second operation is accepted only at E0+34 and returns 1.
- Reset mid-operation: `start` with 100×100, then `rst_n`=0 at the 10th RUN edge -> `busy`/`done`/`product`/`add_a`/`add_b` are all 0 the next cycle and no `done` appears; a following start with 9×9 returns 81.
- Zero and identity: 0×0xDEADBEEF -> 0; 0xDEADBEEF×1 -> 0xDEADBEEF. `add_b`=0 on every RUN cycle where `Q[0]`=0.
- Reset/start collision: `rst_n`=0 and `start`=1 at the same edge -> the block stays in IDLE and `busy` stays 0.
